// File: rtl/t07_fpu_pkg.sv
// Shared opcodes, state encoding and opcode-class helpers for the team_07 FPU sequencer.
package t07_fpu_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned OP_W     = 5;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned FFLAGS_W = 5;

    localparam logic [OP_W-1:0] OP_FMADD     = OP_W'(0);
    localparam logic [OP_W-1:0] OP_FMSUB     = OP_W'(1);
    localparam logic [OP_W-1:0] OP_FNMSUB    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_FNMADD    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_FEQ       = OP_W'(16);
    localparam logic [OP_W-1:0] OP_FLT       = OP_W'(17);
    localparam logic [OP_W-1:0] OP_FLE       = OP_W'(18);
    localparam logic [OP_W-1:0] OP_FCVT_W_S  = OP_W'(19);
    localparam logic [OP_W-1:0] OP_FCVT_WU_S = OP_W'(20);
    localparam logic [OP_W-1:0] OP_FCVT_S_W  = OP_W'(21);
    localparam logic [OP_W-1:0] OP_FCVT_S_WU = OP_W'(22);
    localparam logic [OP_W-1:0] OP_MAX       = OP_W'(22);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } fpu_seq_state_t;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_MAX;
    endfunction

    // int-to-float converts read the integer register file
    function automatic logic op_int_src(input logic [OP_W-1:0] op);
        return (op == OP_FCVT_S_W) || (op == OP_FCVT_S_WU);
    endfunction

    // fused multiply-add family needs the third operand
    function automatic logic op_three_src(input logic [OP_W-1:0] op);
        return (op == OP_FMADD) || (op == OP_FMSUB) || (op == OP_FNMSUB) || (op == OP_FNMADD);
    endfunction

    // compares and float-to-int converts produce an integer result
    function automatic logic op_int_dst(input logic [OP_W-1:0] op);
        return (op == OP_FEQ) || (op == OP_FLT) || (op == OP_FLE) ||
               (op == OP_FCVT_W_S) || (op == OP_FCVT_WU_S);
    endfunction

endpackage

// File: rtl/t07_fpu_operand_sel.sv
// Chooses FPU operands A/B/C from the integer or FP register-file read ports by opcode class.
module t07_fpu_operand_sel
    import t07_fpu_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [31:0] int_a,
    input  logic [31:0] int_b,
    input  logic [31:0] fp_a,
    input  logic [31:0] fp_b,
    input  logic [31:0] fp_c,
    output logic [31:0] a_c,
    output logic [31:0] b_c,
    output logic [31:0] c_c
);

    always_comb begin
        a_c = fp_a;
        b_c = fp_b;
        c_c = '0;
        if (op_int_src(op)) begin
            a_c = int_a;
            b_c = int_b;
        end else if (op_three_src(op)) begin
            c_c = fp_c;
        end
    end

endmodule

// File: rtl/t07_fpu_sequencer.sv
// Sequences one multi-cycle FPU op at a time: latch operands, start, wait for done or
// timeout, write back once and accumulate sticky exception flags.
module t07_fpu_sequencer
    import t07_fpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [4:0]  req_op_i,
    input  logic [4:0]  req_rd_i,
    input  logic [31:0] regValA_i,
    input  logic [31:0] regValB_i,
    input  logic [31:0] fpuRegValA_i,
    input  logic [31:0] fpuRegValB_i,
    input  logic [31:0] fpuRegValC_i,
    input  logic        flush_i,
    output logic        fpu_start_o,
    output logic [4:0]  fpu_op_o,
    output logic [31:0] fpu_a_o,
    output logic [31:0] fpu_b_o,
    output logic [31:0] fpu_c_o,
    input  logic        fpu_done_i,
    input  logic [31:0] fpu_result_i,
    input  logic [4:0]  fpu_flags_i,
    output logic        wb_valid_o,
    output logic        wb_to_int_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  fflags_o,
    input  logic        fflags_clr_i,
    output logic        busy_o,
    output logic        timeout_o,
    output logic        illegal_o
);

    fpu_seq_state_t        state;
    logic [CNT_W-1:0]      wait_cnt;
    logic [REG_W-1:0]      rd_q;
    logic [FFLAGS_W-1:0]   flags_q;
    logic [XLEN-1:0]       sel_a_c;
    logic [XLEN-1:0]       sel_b_c;
    logic [XLEN-1:0]       sel_c_c;
    logic                  wb_commit_c;

    t07_fpu_operand_sel u_operand_sel (
        .op    (req_op_i),
        .int_a (regValA_i),
        .int_b (regValB_i),
        .fp_a  (fpuRegValA_i),
        .fp_b  (fpuRegValB_i),
        .fp_c  (fpuRegValC_i),
        .a_c   (sel_a_c),
        .b_c   (sel_b_c),
        .c_c   (sel_c_c)
    );

    // a flush arriving during writeback drops the flag merge
    assign wb_commit_c = (state == ST_WB) && !flush_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            fpu_start_o <= 1'b0;
            fpu_op_o    <= '0;
            fpu_a_o     <= '0;
            fpu_b_o     <= '0;
            fpu_c_o     <= '0;
            rd_q        <= '0;
            wait_cnt    <= '0;
            flags_q     <= '0;
            wb_valid_o  <= 1'b0;
            wb_to_int_o <= 1'b0;
            wb_rd_o     <= '0;
            wb_data_o   <= '0;
            fflags_o    <= '0;
            timeout_o   <= 1'b0;
            illegal_o   <= 1'b0;
        end else begin
            fpu_start_o <= 1'b0;
            wb_valid_o  <= 1'b0;
            illegal_o   <= 1'b0;
            fflags_o    <= (fflags_clr_i ? '0 : fflags_o) | (wb_commit_c ? flags_q : '0);

            case (state)
                ST_IDLE: begin
                    if (req_valid_i && !flush_i) begin
                        if (op_is_legal(req_op_i)) begin
                            state       <= ST_ISSUE;
                            req_ready_o <= 1'b0;
                            busy_o      <= 1'b1;
                            fpu_start_o <= 1'b1;
                            fpu_op_o    <= req_op_i;
                            rd_q        <= req_rd_i;
                            fpu_a_o     <= sel_a_c;
                            fpu_b_o     <= sel_b_c;
                            fpu_c_o     <= sel_c_c;
                        end else begin
                            illegal_o <= 1'b1;
                        end
                    end
                end

                // ISSUE and WAIT share completion handling; only the no-done path differs
                ST_ISSUE, ST_WAIT: begin
                    if (flush_i) begin
                        state       <= ST_IDLE;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                    end else if (fpu_done_i) begin
                        state       <= ST_WB;
                        wb_valid_o  <= 1'b1;
                        wb_to_int_o <= op_int_dst(fpu_op_o);
                        wb_rd_o     <= rd_q;
                        wb_data_o   <= fpu_result_i;
                        flags_q     <= fpu_flags_i;
                    end else if (state == ST_ISSUE) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state       <= ST_IDLE;
                        req_ready_o <= 1'b1;
                        busy_o      <= 1'b0;
                        timeout_o   <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_WB: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end

                default: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
            endcase
        end
    end

endmodule
